// File: rtl/dnn_accel_system_switch_poller_if.sv
// Avalon-MM read master bus and switch-change event port
// for the switch poller.
interface dnn_accel_system_switch_poller_if;
  logic [31:0] avm_address;
  logic        avm_read;
  logic        avm_waitrequest;
  logic [31:0] avm_readdata;
  logic        avm_readdatavalid;
  logic        evt_valid;
  logic        evt_ready;
  logic [7:0]  evt_data;
  logic [7:0]  evt_changed;
  logic [7:0]  cur_value;

  modport master (
    output avm_address,
    output avm_read,
    input  avm_waitrequest,
    input  avm_readdata,
    input  avm_readdatavalid,
    output evt_valid,
    input  evt_ready,
    output evt_data,
    output evt_changed,
    output cur_value
  );

  modport slave (
    input  avm_address,
    input  avm_read,
    output avm_waitrequest,
    output avm_readdata,
    output avm_readdatavalid,
    input  evt_valid,
    output evt_ready,
    input  evt_data,
    input  evt_changed,
    input  cur_value
  );
endinterface

// File: rtl/dnn_accel_system_switch_poller.sv
// Polls the switch PIO data register, debounces the value
// and reports accepted changes as coalescing events.
module dnn_accel_system_switch_poller #(
  parameter logic [31:0] BASE_ADDR     = 32'h0000_0000,
  parameter int unsigned POLL_INTERVAL = 1000,
  parameter int unsigned STABLE_COUNT  = 3
) (
  input logic clk,
  input logic reset,
  dnn_accel_system_switch_poller_if.master bus
);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] REQ  = 2'd1;
  localparam logic [1:0] WAIT = 2'd2;
  localparam logic [1:0] EVAL = 2'd3;

  localparam logic [15:0] INTERVAL_LAST =
    16'(POLL_INTERVAL - 1);
  localparam logic [3:0] STABLE_MAX = 4'(STABLE_COUNT);

  logic [1:0]  state;
  logic [15:0] interval_cnt;
  logic [7:0]  sample;
  logic [7:0]  last_sample;
  logic [3:0]  stab_cnt;
  logic [3:0]  stab_next;
  logic [7:0]  diff;
  logic        accept;
  logic        take;
  logic        unused_hi;

  assign bus.avm_address = BASE_ADDR;
  assign unused_hi = ^bus.avm_readdata[31:8];

  always_comb begin
    stab_next = 4'd1;
    if (sample == last_sample) begin
      if (stab_cnt >= STABLE_MAX)
        stab_next = STABLE_MAX;
      else
        stab_next = stab_cnt + 4'd1;
    end
    diff   = sample ^ bus.cur_value;
    accept = (state == EVAL)
          && (stab_next == STABLE_MAX)
          && (diff != 8'd0);
    take   = bus.evt_valid && bus.evt_ready;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state        <= IDLE;
      interval_cnt <= '0;
      bus.avm_read <= 1'b0;
      sample       <= '0;
    end else begin
      unique case (state)
        IDLE: begin
          if (interval_cnt == INTERVAL_LAST) begin
            state        <= REQ;
            bus.avm_read <= 1'b1;
          end else begin
            interval_cnt <= interval_cnt + 16'd1;
          end
        end
        REQ: begin
          if (!bus.avm_waitrequest) begin
            state        <= WAIT;
            bus.avm_read <= 1'b0;
          end
        end
        WAIT: begin
          if (bus.avm_readdatavalid) begin
            sample <= bus.avm_readdata[7:0];
            state  <= EVAL;
          end
        end
        EVAL: begin
          state        <= IDLE;
          interval_cnt <= '0;
        end
        default: state <= IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      last_sample <= '0;
      stab_cnt    <= '0;
    end else if (state == EVAL) begin
      last_sample <= sample;
      stab_cnt    <= stab_next;
    end
  end

  // A pending unconsumed event absorbs new changes; a
  // consumed one is replaced by a fresh event.
  always_ff @(posedge clk) begin
    if (reset) begin
      bus.evt_valid   <= 1'b0;
      bus.evt_data    <= '0;
      bus.evt_changed <= '0;
      bus.cur_value   <= '0;
    end else begin
      unique case (1'b1)
        accept: begin
          bus.cur_value <= sample;
          bus.evt_valid <= 1'b1;
          bus.evt_data  <= sample;
          if (bus.evt_valid && !take)
            bus.evt_changed <= bus.evt_changed | diff;
          else
            bus.evt_changed <= diff;
        end
        take: bus.evt_valid <= 1'b0;
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_dnn_accel_system_switch_poller.sv
// Randomized scoreboard bench for the switch poller with a
// directed prologue for reset, stall and mid-read reset.
module tb_dnn_accel_system_switch_poller;

  localparam logic [31:0] BASE = 32'h0000_1230;
  localparam int PI = 4;
  localparam int SC = 2;
  localparam logic [7:0] VALS [4] =
    '{8'h00, 8'h01, 8'h03, 8'h5A};

  logic clk = 1'b0;
  logic reset;

  dnn_accel_system_switch_poller_if bus ();

  dnn_accel_system_switch_poller #(
    .BASE_ADDR    (BASE),
    .POLL_INTERVAL(PI),
    .STABLE_COUNT (SC)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad = 0;
  int delivered = 0;
  bit sb_on = 1'b0;

  logic [15:0] exp_q [$];
  logic [7:0]  hist [$];

  bit          m_valid;
  logic [7:0]  m_data, m_chg, m_cur;
  bit          eval_pend, deliver_pend, acc;
  logic [7:0]  pend_sample, s, dv, prev_val;
  bit          rd_seen, outstanding, rdv_drv, wr_drv;
  logic [31:0] data_drv, tmp;
  int          lat, n;

  task automatic check(input string name,
                       input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  function automatic bit stable_now();
    int sz = hist.size();
    if (sz < SC) return 1'b0;
    for (int i = sz - SC; i < sz; i++)
      if (hist[i] != hist[sz-1]) return 1'b0;
    return 1'b1;
  endfunction

  function automatic logic [7:0] next_val(logic [7:0] p);
    int r = $urandom_range(0, 9);
    if (r < 6) return p;
    if (r < 9) return VALS[$urandom_range(0, 3)];
    return 8'($urandom());
  endfunction

  // Monitor: a transfer happens at the coming edge.
  initial begin
    forever begin
      @(negedge clk);
      #1;
      if (sb_on && !reset && bus.evt_valid && bus.evt_ready) begin
        delivered++;
        if (exp_q.size() == 0) begin
          check("unexpected_event", 1, 0);
        end else begin
          logic [15:0] e;
          e = exp_q.pop_front();
          check("evt_data", int'(bus.evt_data), int'(e[15:8]));
          check("evt_changed", int'(bus.evt_changed),
                int'(e[7:0]));
        end
      end
    end
  end

  task automatic wait_read(output int cnt);
    cnt = 0;
    while (cnt < 50) begin
      @(negedge clk);
      cnt++;
      if (bus.avm_read) break;
    end
  endtask

  initial begin
    reset = 1'b1;
    bus.avm_waitrequest   = 1'b0;
    bus.avm_readdata      = '0;
    bus.avm_readdatavalid = 1'b0;
    bus.evt_ready         = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_evt_valid", int'(bus.evt_valid), 0);
    check("rst_cur_value", int'(bus.cur_value), 0);
    check("rst_avm_read", int'(bus.avm_read), 0);
    check("rst_evt_data", int'(bus.evt_data), 0);
    check("rst_address", int'(bus.avm_address), int'(BASE));

    reset = 1'b0;
    wait_read(n);
    check("first_read_delay", n, PI);

    // Five stalled cycles keep the request up for six.
    n = 0;
    for (int j = 0; j < 12; j++) begin
      if (bus.avm_read) begin
        n++;
        check("stall_address", int'(bus.avm_address), int'(BASE));
      end
      bus.avm_waitrequest = (j < 5);
      @(negedge clk);
    end
    check("stall_read_cycles", n, 6);

    reset = 1'b1;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    n = 0;
    while (n < 50) begin
      @(negedge clk);
      n++;
      bus.avm_readdatavalid = (n == 1);
      bus.avm_readdata = (n == 1) ? 32'h0000_00FF : 32'h0;
      if (bus.avm_read) break;
    end
    check("midread_next_poll", n, PI);
    check("midread_cur_value", int'(bus.cur_value), 0);
    check("midread_evt_valid", int'(bus.evt_valid), 0);

    // Randomized phase against the reference model.
    reset = 1'b1;
    bus.avm_readdatavalid = 1'b0;
    repeat (2) @(negedge clk);
    m_valid = 0; m_data = 0; m_chg = 0; m_cur = 0;
    eval_pend = 0; deliver_pend = 0; pend_sample = 0;
    rd_seen = 0; outstanding = 0; rdv_drv = 0; wr_drv = 0;
    data_drv = 0; lat = 0; prev_val = 0;
    hist.delete();
    exp_q.delete();
    bus.avm_waitrequest = 1'b0;
    bus.evt_ready = 1'b0;
    reset = 1'b0;
    sb_on = 1'b1;

    for (int c = 0; c < 3000; c++) begin
      @(negedge clk);
      acc = 1'b0;
      s = pend_sample;
      if (eval_pend) begin
        hist.push_back(s);
        acc = stable_now() && (s != m_cur);
      end
      if (acc) begin
        if (m_valid && !deliver_pend)
          m_chg = m_chg | (s ^ m_cur);
        else
          m_chg = s ^ m_cur;
        m_data = s;
        m_cur = s;
        m_valid = 1'b1;
      end else if (deliver_pend) begin
        m_valid = 1'b0;
      end
      eval_pend = rdv_drv;
      pend_sample = data_drv[7:0];
      if (rd_seen && !wr_drv) begin
        outstanding = 1'b1;
        lat = $urandom_range(0, 3);
      end

      rdv_drv = 1'b0;
      if (outstanding) begin
        if (lat == 0) begin
          dv = next_val(prev_val);
          prev_val = dv;
          tmp = $urandom();
          data_drv = {tmp[31:8], dv};
          rdv_drv = 1'b1;
          outstanding = 1'b0;
        end else begin
          lat--;
        end
      end
      wr_drv = ($urandom_range(0, 4) < 2);
      bus.avm_waitrequest = wr_drv;
      bus.avm_readdatavalid = rdv_drv;
      bus.avm_readdata = rdv_drv ? data_drv : 32'($urandom());
      bus.evt_ready = ($urandom_range(0, 3) == 0);
      rd_seen = bus.avm_read;
      deliver_pend = m_valid && bus.evt_ready;
      if (deliver_pend) exp_q.push_back({m_data, m_chg});
    end
    #2;
    check("final_queue_empty", exp_q.size(), 0);
    check("final_cur_value", int'(bus.cur_value), int'(m_cur));
    check("final_evt_valid", int'(bus.evt_valid), int'(m_valid));
    if (m_valid)
      check("final_evt_data", int'(bus.evt_data), int'(m_data));
    check("events_seen", int'(delivered > 0), 1);
    sb_on = 1'b0;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
